// File: rtl/mem_store_buffer.sv
// Store buffer between EX/MEM and data memory. Stores drain one cycle after enqueue at the earliest; Stall_MEM holds the pipeline when full with no drain, or when a load cannot complete.
// Loads win the memory port. With STORE_FWD_EN a load hitting the buffer is forwarded; otherwise it stalls until the hit has drained.
module mem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [31:0]      ALU_Result_MEM,
  input  logic [31:0]      Write_Data_MEM,
  input  logic             MemWrite_MEM,
  input  logic             MemRead_MEM,
  input  logic             Mem_Ready,
  input  logic [31:0]      Mem_Read_Data,
  output logic [31:0]      Mem_Address,
  output logic [31:0]      Mem_Write_Data,
  output logic             Mem_Write,
  output logic             Mem_Read,
  output logic [31:0]      Read_Data_MEM,
  output logic             Stall_MEM,
  output logic [CNT_W-1:0] Count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [29:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;

  logic             match, hit, load_port, drain, enq;
  logic             store_stall, load_stall;
  logic [31:0]      fwd_data;
  logic [PTR_W-1:0] idx;

  // Scan oldest to youngest so the last match wins (youngest store).
  always_comb begin
    match    = 1'b0;
    fwd_data = 32'h0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (addr_q[idx] == ALU_Result_MEM[31:2])) begin
        match    = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

  assign hit       = MemRead_MEM & match;
  assign load_port = MemRead_MEM & ~hit & Mem_Ready;
  assign drain     = (count_q != '0) & Mem_Ready & ~load_port;
  assign enq       = MemWrite_MEM & ((count_q < CNT_W'(DEPTH)) | drain);

  assign store_stall = MemWrite_MEM & ~enq;
`ifdef STORE_FWD_EN
  assign load_stall  = MemRead_MEM & ~hit & ~Mem_Ready;
`else
  // A hit must wait for its entry to reach memory before the load may read it.
  assign load_stall  = MemRead_MEM & (hit | ~Mem_Ready);
`endif
  assign Stall_MEM   = store_stall | load_stall;
  assign Count       = count_q;

  always_comb begin
    Mem_Address    = ALU_Result_MEM;
    Mem_Write_Data = data_q[head_q];
    Mem_Write      = 1'b0;
    Mem_Read       = 1'b0;
    Read_Data_MEM  = 32'h0;
    if (load_port) begin
      Mem_Read      = 1'b1;
      Read_Data_MEM = Mem_Read_Data;
    end else if (drain) begin
      Mem_Write   = 1'b1;
      Mem_Address = {addr_q[head_q], 2'b00};
    end
`ifdef STORE_FWD_EN
    if (hit) Read_Data_MEM = fwd_data;
`endif
  end

  always_ff @(posedge Clk) begin
    if (enq) begin
      addr_q[tail_q] <= ALU_Result_MEM[31:2];
      data_q[tail_q] <= Write_Data_MEM;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq)   tail_q <= tail_q + PTR_W'(1);
      if (drain) head_q <= head_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(enq) - CNT_W'(drain);
    end
  end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Directed self-checking bench for mem_store_buffer (DEPTH=4); logs memory writes at negedge.
module tb_mem_store_buffer;
  logic        Clk, Reset;
  logic [31:0] ALU_Result_MEM, Write_Data_MEM, Mem_Read_Data;
  logic        MemWrite_MEM, MemRead_MEM, Mem_Ready;
  logic [31:0] Mem_Address, Mem_Write_Data, Read_Data_MEM;
  logic        Mem_Write, Mem_Read, Stall_MEM;
  logic [2:0]  Count;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  mem_store_buffer #(.DEPTH(4)) dut (
    .Clk(Clk), .Reset(Reset),
    .ALU_Result_MEM(ALU_Result_MEM), .Write_Data_MEM(Write_Data_MEM),
    .MemWrite_MEM(MemWrite_MEM), .MemRead_MEM(MemRead_MEM),
    .Mem_Ready(Mem_Ready), .Mem_Read_Data(Mem_Read_Data),
    .Mem_Address(Mem_Address), .Mem_Write_Data(Mem_Write_Data),
    .Mem_Write(Mem_Write), .Mem_Read(Mem_Read),
    .Read_Data_MEM(Read_Data_MEM), .Stall_MEM(Stall_MEM), .Count(Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (Mem_Write) begin
      wa_q.push_back(Mem_Address);
      wd_q.push_back(Mem_Write_Data);
    end
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs;
    MemWrite_MEM = 0; MemRead_MEM = 0; Mem_Ready = 0;
    ALU_Result_MEM = 0; Write_Data_MEM = 0; Mem_Read_Data = 0;
  endtask

  task automatic drain_all;
    int cyc;
    idle_inputs();
    Mem_Ready = 1;
    cyc = 0;
    while (Count != 0 && cyc < 20) begin tick(); cyc++; end
    n_checks++;
    if (Count !== 3'd0) begin n_errors++; $display("FAIL drain_timeout count=%0d required 0", Count); end
    Mem_Ready = 0;
  endtask

  task automatic test_reset;
    int n;
    Reset = 1; idle_inputs();
    #3;
    n_checks++; if (Count !== 3'd0)  begin n_errors++; $display("FAIL rst_count got %0d want 0", Count); end
    n_checks++; if (Stall_MEM !== 1'b0) begin n_errors++; $display("FAIL rst_stall got %b want 0", Stall_MEM); end
    n_checks++; if (Mem_Write !== 1'b0) begin n_errors++; $display("FAIL rst_mem_write got %b want 0", Mem_Write); end
    n_checks++; if (Mem_Read !== 1'b0)  begin n_errors++; $display("FAIL rst_mem_read got %b want 0", Mem_Read); end
    n_checks++; if (Read_Data_MEM !== 32'h0) begin n_errors++; $display("FAIL rst_rdata got %h want 0", Read_Data_MEM); end
    tick(); Reset = 0;
    // build up two buffered stores, then hit reset while a drain is pending
    MemWrite_MEM = 1; ALU_Result_MEM = 32'h100; Write_Data_MEM = 32'h1; tick();
    ALU_Result_MEM = 32'h104; Write_Data_MEM = 32'h2; tick();
    MemWrite_MEM = 0; #1;
    n_checks++; if (Count !== 3'd2) begin n_errors++; $display("FAIL rst_pre_count got %0d want 2", Count); end
    Mem_Ready = 1; #1;
    n_checks++; if (Mem_Write !== 1'b1) begin n_errors++; $display("FAIL rst_pre_drain got %b want 1", Mem_Write); end
    n = wa_q.size();
    Reset = 1; #1;
    n_checks++; if (Count !== 3'd0) begin n_errors++; $display("FAIL rst_mid_count got %0d want 0", Count); end
    n_checks++; if (Stall_MEM !== 1'b0) begin n_errors++; $display("FAIL rst_mid_stall got %b want 0", Stall_MEM); end
    n_checks++; if (Mem_Write !== 1'b0) begin n_errors++; $display("FAIL rst_mid_write got %b want 0", Mem_Write); end
    n_checks++; if (Read_Data_MEM !== 32'h0) begin n_errors++; $display("FAIL rst_mid_rdata got %h want 0", Read_Data_MEM); end
    @(negedge Clk); #1;
    n_checks++; if (wa_q.size() !== n) begin n_errors++; $display("FAIL rst_no_write got %0d writes want %0d", wa_q.size(), n); end
    tick(); Reset = 0; Mem_Ready = 0;
  endtask

  task automatic test_single_store;
    wa_q.delete(); wd_q.delete();
    idle_inputs();
    Mem_Ready = 1; MemWrite_MEM = 1; ALU_Result_MEM = 32'h10; Write_Data_MEM = 32'hDEADBEEF; #1;
    n_checks++; if (Stall_MEM !== 1'b0) begin n_errors++; $display("FAIL single_stall got %b want 0", Stall_MEM); end
    tick();
    MemWrite_MEM = 0; ALU_Result_MEM = 32'h0; #1;
    n_checks++; if (Count !== 3'd1) begin n_errors++; $display("FAIL single_count1 got %0d want 1", Count); end
    n_checks++; if (Mem_Write !== 1'b1) begin n_errors++; $display("FAIL single_write got %b want 1", Mem_Write); end
    n_checks++; if (Mem_Address !== 32'h10) begin n_errors++; $display("FAIL single_addr got %h want 00000010", Mem_Address); end
    n_checks++; if (Mem_Write_Data !== 32'hDEADBEEF) begin n_errors++; $display("FAIL single_wdata got %h want deadbeef", Mem_Write_Data); end
    tick();
    n_checks++; if (Count !== 3'd0) begin n_errors++; $display("FAIL single_count0 got %0d want 0", Count); end
    n_checks++; if (Mem_Write !== 1'b0) begin n_errors++; $display("FAIL single_idle_write got %b want 0", Mem_Write); end
    n_checks++;
    if (wa_q.size() != 1 || wa_q[0] !== 32'h10 || wd_q[0] !== 32'hDEADBEEF) begin
      n_errors++; $display("FAIL single_memlog got %0d writes want 1 (10/deadbeef)", wa_q.size());
    end
  endtask

  task automatic test_fill;
    logic [31:0] exp_a [5];
    wa_q.delete(); wd_q.delete();
    idle_inputs();
    MemWrite_MEM = 1;
    for (int i = 0; i < 4; i++) begin
      ALU_Result_MEM = 32'(i * 4); Write_Data_MEM = 32'hA0 + 32'(i); #1;
      n_checks++; if (Stall_MEM !== 1'b0) begin n_errors++; $display("FAIL fill_stall%0d got %b want 0", i, Stall_MEM); end
      tick();
    end
    ALU_Result_MEM = 32'h10; Write_Data_MEM = 32'hA4; #1;
    n_checks++; if (Count !== 3'd4) begin n_errors++; $display("FAIL fill_count got %0d want 4", Count); end
    n_checks++; if (Stall_MEM !== 1'b1) begin n_errors++; $display("FAIL fill_full_stall got %b want 1", Stall_MEM); end
    Mem_Ready = 1; #1;
    n_checks++; if (Stall_MEM !== 1'b0) begin n_errors++; $display("FAIL fill_accept_stall got %b want 0", Stall_MEM); end
    tick();
    MemWrite_MEM = 0; #1;
    n_checks++; if (Count !== 3'd4) begin n_errors++; $display("FAIL fill_count_hold got %0d want 4", Count); end
    drain_all();
    exp_a[0] = 32'h0; exp_a[1] = 32'h4; exp_a[2] = 32'h8; exp_a[3] = 32'hC; exp_a[4] = 32'h10;
    n_checks++; if (wa_q.size() != 5) begin n_errors++; $display("FAIL fill_nwrites got %0d want 5", wa_q.size()); end
    for (int i = 0; i < 5 && i < wa_q.size(); i++) begin
      n_checks++;
      if (wa_q[i] !== exp_a[i] || wd_q[i] !== 32'hA0 + 32'(i)) begin
        n_errors++; $display("FAIL fill_order%0d got %h/%h want %h/%h", i, wa_q[i], wd_q[i], exp_a[i], 32'hA0 + 32'(i));
      end
    end
  endtask

  task automatic test_back_to_back;
    wa_q.delete(); wd_q.delete();
    idle_inputs();
    Mem_Ready = 1; MemWrite_MEM = 1;
    for (int i = 0; i < 3; i++) begin
      ALU_Result_MEM = 32'h300 + 32'(i * 4); Write_Data_MEM = 32'hB0 + 32'(i); #1;
      n_checks++; if (Stall_MEM !== 1'b0) begin n_errors++; $display("FAIL b2b_stall%0d got %b want 0", i, Stall_MEM); end
      tick();
      n_checks++; if (Count !== 3'd1) begin n_errors++; $display("FAIL b2b_count%0d got %0d want 1", i, Count); end
    end
    drain_all();
    n_checks++;
    if (wa_q.size() != 3 || wa_q[2] !== 32'h308 || wd_q[2] !== 32'hB2) begin
      n_errors++; $display("FAIL b2b_memlog got %0d writes want 3 ending 308/b2", wa_q.size());
    end
  endtask

  task automatic test_load_priority;
    idle_inputs();
    MemWrite_MEM = 1; ALU_Result_MEM = 32'h200; Write_Data_MEM = 32'h5; tick();
    ALU_Result_MEM = 32'h204; tick();
    MemWrite_MEM = 0;
    MemRead_MEM = 1; ALU_Result_MEM = 32'h40; Mem_Ready = 1; Mem_Read_Data = 32'hCAFEF00D; #1;
    n_checks++; if (Mem_Read !== 1'b1) begin n_errors++; $display("FAIL prio_read got %b want 1", Mem_Read); end
    n_checks++; if (Mem_Write !== 1'b0) begin n_errors++; $display("FAIL prio_write got %b want 0", Mem_Write); end
    n_checks++; if (Mem_Address !== 32'h40) begin n_errors++; $display("FAIL prio_addr got %h want 00000040", Mem_Address); end
    n_checks++; if (Read_Data_MEM !== 32'hCAFEF00D) begin n_errors++; $display("FAIL prio_rdata got %h want cafef00d", Read_Data_MEM); end
    n_checks++; if (Stall_MEM !== 1'b0) begin n_errors++; $display("FAIL prio_stall got %b want 0", Stall_MEM); end
    tick();
    n_checks++; if (Count !== 3'd2) begin n_errors++; $display("FAIL prio_count got %0d want 2", Count); end
    Mem_Ready = 0; #1;
    n_checks++; if (Stall_MEM !== 1'b1) begin n_errors++; $display("FAIL prio_notready_stall got %b want 1", Stall_MEM); end
    n_checks++; if (Mem_Read !== 1'b0) begin n_errors++; $display("FAIL prio_notready_read got %b want 0", Mem_Read); end
    drain_all();
  endtask

`ifdef STORE_FWD_EN
  task automatic test_forward;
    idle_inputs();
    MemWrite_MEM = 1; ALU_Result_MEM = 32'h20; Write_Data_MEM = 32'h11111111; tick();
    Write_Data_MEM = 32'h22222222; tick();
    MemWrite_MEM = 0; MemRead_MEM = 1; ALU_Result_MEM = 32'h22; Mem_Read_Data = 32'h99999999; #1;
    n_checks++; if (Read_Data_MEM !== 32'h22222222) begin n_errors++; $display("FAIL fwd_rdata got %h want 22222222", Read_Data_MEM); end
    n_checks++; if (Stall_MEM !== 1'b0) begin n_errors++; $display("FAIL fwd_stall got %b want 0", Stall_MEM); end
    n_checks++; if (Mem_Read !== 1'b0) begin n_errors++; $display("FAIL fwd_read got %b want 0", Mem_Read); end
    drain_all();
  endtask
`else
  task automatic test_no_forward;
    idle_inputs();
    MemWrite_MEM = 1; ALU_Result_MEM = 32'h20; Write_Data_MEM = 32'h33333333; tick();
    MemWrite_MEM = 0; MemRead_MEM = 1; Mem_Ready = 1; Mem_Read_Data = 32'h12345678; #1;
    n_checks++; if (Stall_MEM !== 1'b1) begin n_errors++; $display("FAIL nofwd_stall got %b want 1", Stall_MEM); end
    n_checks++; if (Mem_Write !== 1'b1) begin n_errors++; $display("FAIL nofwd_drain got %b want 1", Mem_Write); end
    n_checks++; if (Mem_Read !== 1'b0) begin n_errors++; $display("FAIL nofwd_read_early got %b want 0", Mem_Read); end
    tick();
    n_checks++; if (Stall_MEM !== 1'b0) begin n_errors++; $display("FAIL nofwd_release got %b want 0", Stall_MEM); end
    n_checks++; if (Mem_Read !== 1'b1) begin n_errors++; $display("FAIL nofwd_read got %b want 1", Mem_Read); end
    n_checks++; if (Mem_Address !== 32'h20) begin n_errors++; $display("FAIL nofwd_addr got %h want 00000020", Mem_Address); end
    n_checks++; if (Read_Data_MEM !== 32'h12345678) begin n_errors++; $display("FAIL nofwd_rdata got %h want 12345678", Read_Data_MEM); end
    drain_all();
  endtask
`endif

  initial begin
    test_reset();
    test_single_store();
    test_fill();
    test_back_to_back();
    test_load_priority();
`ifdef STORE_FWD_EN
    test_forward();
`else
    test_no_forward();
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
